rf_write_port_driver: RTL

//  Drives the register-file write port (RegWEn/DAddr/Ddata) from the writeback side of the pipeline.
//  - Selects and formats the MEM/WB result: ALU, load data, or PC+4.
//  - Merges results from a long-latency unit (mul/div) through a small FIFO.
//  - Pipeline results always win the single write port; long-latency results drain into free slots.

---
 rtl/rf_write_port_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rf_write_port_driver.sv
// Register-file write port driver.
// Picks and formats the MEM/WB result (ALU, load, PC+4) and merges results
// from a long-latency unit through a small FIFO. The pipeline always owns the
// single write port; queued long-latency results drain into idle cycles.
module rf_write_port_driver #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mw_valid,
  input  logic [AW-1:0]             mw_rd,
  input  logic [1:0]                mw_wb_sel,
  input  logic [XLEN-1:0]           mw_alu,
  input  logic [XLEN-1:0]           mw_mem,
  input  logic [XLEN-1:0]           mw_pc4,
  input  logic [2:0]                mw_funct3,
  input  logic [1:0]                mw_boff,
  input  logic                      lu_valid,
  output logic                      lu_ready,
  input  logic [AW-1:0]             lu_rd,
  input  logic [XLEN-1:0]           lu_data,
  output logic                      RegWEn,
  output logic [AW-1:0]             DAddr,
  output logic [XLEN-1:0]           Ddata,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  logic            wbWrite;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] wbData;
  logic            push;
  logic            pop;
  logic [AW-1:0]   headRd;
  logic [XLEN-1:0] headData;

  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;

  logic [AW-1:0]   qRd_q   [QDEPTH];
  logic [XLEN-1:0] qData_q [QDEPTH];

  // A pipeline write needs a valid instruction, a writing wb_sel and a non-x0 target
  assign wbWrite  = mw_valid & (mw_wb_sel != 2'b11) & (mw_rd != '0);

  // Ready comes from the registered count only, so a full FIFO never passes through
  assign lu_ready = rst & (count_q < QFULL);
  assign push     = lu_valid & lu_ready;
  assign pop      = (count_q != '0) & ~wbWrite;
  assign headRd   = qRd_q[rptr_q];
  assign headData = qData_q[rptr_q];

  // Extract byte/half from the aligned load word and extend by load type
  always_comb begin
    byteSel  = 8'h00;
    halfSel  = mw_boff[1] ? mw_mem[31:16] : mw_mem[15:0];
    loadData = mw_mem;
    case (mw_boff)
      2'd0:    byteSel = mw_mem[7:0];
      2'd1:    byteSel = mw_mem[15:8];
      2'd2:    byteSel = mw_mem[23:16];
      default: byteSel = mw_mem[31:24];
    endcase
    case (mw_funct3)
      3'b000:  loadData = {{(XLEN-8){byteSel[7]}}, byteSel};
      3'b001:  loadData = {{(XLEN-16){halfSel[15]}}, halfSel};
      3'b100:  loadData = {{(XLEN-8){1'b0}}, byteSel};
      3'b101:  loadData = {{(XLEN-16){1'b0}}, halfSel};
      default: loadData = mw_mem;
    endcase
  end

  // Writeback source select
  always_comb begin
    wbData = '0;
    case (mw_wb_sel)
      2'b00:   wbData = mw_alu;
      2'b01:   wbData = loadData;
      2'b10:   wbData = mw_pc4;
      default: wbData = '0;
    endcase
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at QDEPTH
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-port arbitration: pipeline first, else FIFO head; x0 entries pop silently
  always_comb begin
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (wbWrite) begin
      wen_d  = 1'b1;
      addr_d = mw_rd;
      data_d = wbData;
    end else if (pop && (headRd != '0)) begin
      wen_d  = 1'b1;
      addr_d = headRd;
      data_d = headData;
    end
  end

  // FIFO storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      qRd_q[wptr_q]   <= lu_rd;
      qData_q[wptr_q] <= lu_data;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign RegWEn  = wen_q;
  assign DAddr   = addr_q;
  assign Ddata   = data_q;
  assign q_count = count_q;

endmodule
